// File: rtl/data_ram_sync_dp.sv
// Parametrised true dual-port synchronous RAM shared by the load/store unit (port A)
// and the DMA/video path (port B), with an optional zero-fill sequencer after reset.
module data_ram_sync_dp #(
  parameter int DATA_WIDTH     = 24,
  parameter int ADDR_WIDTH     = 17,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_NEW_DATA   = 0,
  parameter int B_WINS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_enable_a,
  input  logic                  write_enable_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic                  read_valid_a,
  input  logic                  read_enable_b,
  input  logic                  write_enable_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  read_valid_b,
  output logic                  busy,
  output logic                  collision,
  output logic                  addr_error
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam bit                  B_PRI    = (B_WINS != 0);
  localparam bit                  RDW_NEW  = (RDW_NEW_DATA != 0);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    in_range_a, in_range_b, same_addr;
  logic [IDX_W-1:0]        idx_a, idx_b;
  logic                    wr_a_ok, wr_b_ok, dual_wr, wr_a_eff, wr_b_eff;
  logic                    rd_a_ok, rd_b_ok;
  logic [DATA_WIDTH-1:0]   rd_word_a, rd_word_b;
  logic                    v1_a, v1_b;
  logic [DATA_WIDTH-1:0]   d1_a, d1_b;

  // ---------------- zero-fill sequencer ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == LAST_IDX) state_nxt = ST_READY;
  end

  always_comb begin
    busy = (state == ST_CLEAR);
  end

  always_ff @(posedge clock) begin
    if (reset)                  clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---------------- request qualification ----------------
  assign in_range_a = {1'b0, address_a} < DEPTH_L;
  assign in_range_b = {1'b0, address_b} < DEPTH_L;
  assign idx_a      = address_a[IDX_W-1:0];
  assign idx_b      = address_b[IDX_W-1:0];
  assign same_addr  = (address_a == address_b);

  assign wr_a_ok  = ~busy & write_enable_a & in_range_a;
  assign wr_b_ok  = ~busy & write_enable_b & in_range_b;
  assign dual_wr  = wr_a_ok & wr_b_ok & same_addr;
  // The losing port of a same-address dual write is suppressed so only one write lands.
  assign wr_a_eff = wr_a_ok & ~(dual_wr & B_PRI);
  assign wr_b_eff = wr_b_ok & ~(dual_wr & ~B_PRI);
  assign rd_a_ok  = ~busy & read_enable_a;
  assign rd_b_ok  = ~busy & read_enable_b;

  // ---------------- storage ----------------
  // NOTE: the array has no reset branch; clearing it is the sequencer's job, one word per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr_a_eff) mem[idx_a] <= write_data_a;
        if (wr_b_eff) mem[idx_b] <= write_data_b;
      end
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_word_a = '0;
    if (in_range_a) begin
      rd_word_a = mem[idx_a];
      if (RDW_NEW) begin
        if (wr_b_eff && same_addr) rd_word_a = write_data_b;
        else if (wr_a_eff)         rd_word_a = write_data_a;
      end
    end
  end

  always_comb begin
    rd_word_b = '0;
    if (in_range_b) begin
      rd_word_b = mem[idx_b];
      if (RDW_NEW) begin
        if (wr_a_eff && same_addr) rd_word_b = write_data_a;
        else if (wr_b_eff)         rd_word_b = write_data_b;
      end
    end
  end

  // ---------------- read pipeline ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1_a <= rd_a_ok;
      v1_b <= rd_b_ok;
      if (rd_a_ok) d1_a <= rd_word_a;
      if (rd_b_ok) d1_b <= rd_word_b;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_a, v2_b;
      logic [DATA_WIDTH-1:0] d2_a, d2_b;

      always_ff @(posedge clock) begin
        if (reset) begin
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          d2_a <= '0;
          d2_b <= '0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end

      assign read_data_a  = d2_a;
      assign read_valid_a = v2_a;
      assign read_data_b  = d2_b;
      assign read_valid_b = v2_b;
    end else begin : g_lat1
      assign read_data_a  = d1_a;
      assign read_valid_a = v1_a;
      assign read_data_b  = d1_b;
      assign read_valid_b = v1_b;
    end
  endgenerate

  // ---------------- status strobes ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      collision  <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      collision  <= dual_wr;
      addr_error <= ~busy &
                    (((read_enable_a | write_enable_a) & ~in_range_a) |
                     ((read_enable_b | write_enable_b) & ~in_range_b));
    end
  end

endmodule

// File: tb/tb_data_ram_sync_dp.sv
// Directed bench: two 16-word RAM instances on shared stimulus, one with latency 1 /
// old-data / A-wins and one with latency 2 / new-data / B-wins.
module tb_data_ram_sync_dp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        re_a = 1'b0, we_a = 1'b0, re_b = 1'b0, we_b = 1'b0;
  logic [4:0]  addr_a = '0, addr_b = '0;
  logic [23:0] wd_a = '0, wd_b = '0;

  logic [23:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        rv_a0, rv_b0, rv_a1, rv_b1;
  logic        busy0, busy1, col0, col1, ae0, ae1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_ram_sync_dp #(
    .DATA_WIDTH(24), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1),
    .RDW_NEW_DATA(0), .B_WINS(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clock(clock), .reset(reset),
    .read_enable_a(re_a), .write_enable_a(we_a), .address_a(addr_a),
    .write_data_a(wd_a), .read_data_a(rd_a0), .read_valid_a(rv_a0),
    .read_enable_b(re_b), .write_enable_b(we_b), .address_b(addr_b),
    .write_data_b(wd_b), .read_data_b(rd_b0), .read_valid_b(rv_b0),
    .busy(busy0), .collision(col0), .addr_error(ae0)
  );

  data_ram_sync_dp #(
    .DATA_WIDTH(24), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2),
    .RDW_NEW_DATA(1), .B_WINS(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clock(clock), .reset(reset),
    .read_enable_a(re_a), .write_enable_a(we_a), .address_a(addr_a),
    .write_data_a(wd_a), .read_data_a(rd_a1), .read_valid_a(rv_a1),
    .read_enable_b(re_b), .write_enable_b(we_b), .address_b(addr_b),
    .write_data_b(wd_b), .read_data_b(rd_b1), .read_valid_b(rv_b1),
    .busy(busy1), .collision(col1), .addr_error(ae1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    re_a = 1'b0; we_a = 1'b0; re_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Counts busy cycles of both instances from the current point; bounded loop.
  task automatic wait_clear(input string tag, input bit chk_rv);
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 64; k++) begin
      if (!busy0 && !busy1) break;
      if (busy0) n0++;
      if (busy1) n1++;
      if (chk_rv) begin
        check({tag, "_rv_a0_busy"}, {31'd0, rv_a0}, 32'd0);
        check({tag, "_rv_a1_busy"}, {31'd0, rv_a1}, 32'd0);
      end
      tick();
    end
    check({tag, "_busy_cycles0"}, n0, 32'd16);
    check({tag, "_busy_cycles1"}, n1, 32'd16);
  endtask

  initial begin
    // Reset state
    tick();
    reset = 1'b0;
    check("rst_rv_a0", {31'd0, rv_a0}, 32'd0);
    check("rst_rd_a0", {8'd0, rd_a0}, 32'd0);
    check("rst_rv_b1", {31'd0, rv_b1}, 32'd0);
    check("rst_col0",  {31'd0, col0},  32'd0);
    check("rst_ae1",   {31'd0, ae1},   32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    wait_clear("init", 1'b0);

    // 1. Preload all ones, reset, verify zero fill
    for (int i = 0; i < 16; i++) begin
      we_a = 1'b1; addr_a = 5'(i); wd_a = 24'hFFFFFF;
      tick();
    end
    idle();
    pulse_reset();
    wait_clear("clr", 1'b0);
    for (int i = 0; i < 16; i++) begin
      re_a = 1'b1; addr_a = 5'(i);
      tick();
      check("clr_rd_a0", {8'd0, rd_a0}, 32'd0);
      check("clr_rv_a0", {31'd0, rv_a0}, 32'd1);
      check("clr_rv_a1", {31'd0, rv_a1}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("clr_rd_a1", {8'd0, rd_a1}, 32'd0);
    end
    idle();
    tick();
    check("clr_last_rv_a1", {31'd0, rv_a1}, 32'd1);
    check("clr_last_rd_a1", {8'd0, rd_a1}, 32'd0);
    check("clr_last_rv_a0", {31'd0, rv_a0}, 32'd0);

    // 2. Latency: write @3 on A, read @3 on B
    we_a = 1'b1; addr_a = 5'd3; wd_a = 24'h123456;
    tick();
    idle();
    re_b = 1'b1; addr_b = 5'd3;
    tick();
    idle();
    check("lat_rv_b0", {31'd0, rv_b0}, 32'd1);
    check("lat_rd_b0", {8'd0, rd_b0}, 32'h123456);
    check("lat_rv_b1_early", {31'd0, rv_b1}, 32'd0);
    tick();
    check("lat_rv_b0_off", {31'd0, rv_b0}, 32'd0);
    check("lat_rd_b0_hold", {8'd0, rd_b0}, 32'h123456);
    check("lat_rv_b1", {31'd0, rv_b1}, 32'd1);
    check("lat_rd_b1", {8'd0, rd_b1}, 32'h123456);

    // Back-to-back reads @3, @4
    we_a = 1'b1; addr_a = 5'd4; wd_a = 24'h000444;
    tick();
    idle();
    re_b = 1'b1; addr_b = 5'd3;
    tick();
    check("b2b_rv_b0_1", {31'd0, rv_b0}, 32'd1);
    check("b2b_rd_b0_1", {8'd0, rd_b0}, 32'h123456);
    addr_b = 5'd4;
    tick();
    idle();
    check("b2b_rv_b0_2", {31'd0, rv_b0}, 32'd1);
    check("b2b_rd_b0_2", {8'd0, rd_b0}, 32'h000444);
    check("b2b_rv_b1_1", {31'd0, rv_b1}, 32'd1);
    check("b2b_rd_b1_1", {8'd0, rd_b1}, 32'h123456);
    tick();
    check("b2b_rv_b0_3", {31'd0, rv_b0}, 32'd0);
    check("b2b_rv_b1_2", {31'd0, rv_b1}, 32'd1);
    check("b2b_rd_b1_2", {8'd0, rd_b1}, 32'h000444);
    tick();
    check("b2b_rv_b1_3", {31'd0, rv_b1}, 32'd0);

    // 3. Dual write @5
    we_a = 1'b1; addr_a = 5'd5; wd_a = 24'hAAAAAA;
    we_b = 1'b1; addr_b = 5'd5; wd_b = 24'hBBBBBB;
    tick();
    idle();
    check("col0_pulse", {31'd0, col0}, 32'd1);
    check("col1_pulse", {31'd0, col1}, 32'd1);
    tick();
    check("col0_off", {31'd0, col0}, 32'd0);
    re_a = 1'b1; addr_a = 5'd5;
    tick();
    idle();
    check("col_rd_a0", {8'd0, rd_a0}, 32'hAAAAAA);
    tick();
    check("col_rd_a1", {8'd0, rd_a1}, 32'hBBBBBB);

    // 4. Read-during-write @7
    we_a = 1'b1; addr_a = 5'd7; wd_a = 24'h000011;
    tick();
    wd_a = 24'h000022;
    re_b = 1'b1; addr_b = 5'd7;
    tick();
    idle();
    check("rdw_rv_b0", {31'd0, rv_b0}, 32'd1);
    check("rdw_rd_b0", {8'd0, rd_b0}, 32'h000011);
    tick();
    check("rdw_rv_b1", {31'd0, rv_b1}, 32'd1);
    check("rdw_rd_b1", {8'd0, rd_b1}, 32'h000022);
    re_a = 1'b1; addr_a = 5'd7;
    tick();
    idle();
    check("rdw_after_a0", {8'd0, rd_a0}, 32'h000022);

    // 5. Out of range @20
    we_a = 1'b1; addr_a = 5'd20; wd_a = 24'h0F0F0F;
    tick();
    idle();
    check("oor_ae0", {31'd0, ae0}, 32'd1);
    check("oor_ae1", {31'd0, ae1}, 32'd1);
    tick();
    check("oor_ae0_off", {31'd0, ae0}, 32'd0);
    re_a = 1'b1; addr_a = 5'd4;
    tick();
    idle();
    check("oor_alias_a0", {8'd0, rd_a0}, 32'h000444);
    tick();
    check("oor_alias_a1", {8'd0, rd_a1}, 32'h000444);
    re_a = 1'b1; addr_a = 5'd20;
    tick();
    idle();
    check("oor_rd_a0", {8'd0, rd_a0}, 32'd0);
    check("oor_rv_a0", {31'd0, rv_a0}, 32'd1);
    check("oor_rd_ae0", {31'd0, ae0}, 32'd1);
    tick();
    check("oor_rd_a1", {8'd0, rd_a1}, 32'd0);
    check("oor_rv_a1", {31'd0, rv_a1}, 32'd1);
    re_a = 1'b1; addr_a = 5'd20; re_b = 1'b1; addr_b = 5'd31;
    tick();
    idle();
    check("oor_both_ae0", {31'd0, ae0}, 32'd1);
    tick();
    check("oor_both_ae0_off", {31'd0, ae0}, 32'd0);

    // 6. Reset mid-clear restarts the fill; reads while busy are ignored
    pulse_reset();
    re_a = 1'b1; addr_a = 5'd3;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("mid_busy0", {31'd0, busy0}, 32'd1);
      check("mid_rv_a0", {31'd0, rv_a0}, 32'd0);
    end
    pulse_reset();
    wait_clear("restart", 1'b1);
    idle();
    check("restart_rv_a0", {31'd0, rv_a0}, 32'd0);
    check("restart_busy1", {31'd0, busy1}, 32'd0);
    re_a = 1'b1; addr_a = 5'd3;
    tick();
    idle();
    check("restart_rd_a0", {8'd0, rd_a0}, 32'd0);
    check("restart_rv_a0_on", {31'd0, rv_a0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_sync_dp.md
Name: data_ram_sync_dp

Overview:
- Parametrised successor to the 24-bit dual-port data RAM: two independent read/write ports on one shared clock.
- Adds configurable width and depth, configurable read latency and a deterministic same-address collision policy.
- Adds an optional zero-fill sequencer that runs after reset, plus per-port read-valid strobes and an out-of-range flag.
- Sits between the core's load/store unit (port A) and the DMA/video path (port B).

Parameters:
DATA_WIDTH, 24, word width in bits
ADDR_WIDTH, 17, address width in bits
DEPTH, 2**ADDR_WIDTH, number of implemented words (must be ≤ 2**ADDR_WIDTH)
READ_LATENCY, 1, cycles from sampled read_enable to read_data/read_valid; legal values 1 or 2
RDW_NEW_DATA, 0, same-address read-during-write: 0 = return old word, 1 = return newly written word
B_WINS, 0, same-address dual write: 0 = port A value stored, 1 = port B value stored
CLEAR_ON_RESET, 1, 1 = zero-fill all DEPTH words after reset

Ports:
clock  in  1  single clock for both ports
reset  in  1  synchronous, active-high
read_enable_a  in  1  port A read request
write_enable_a  in  1  port A write request
address_a  in  ADDR_WIDTH  port A word address
write_data_a  in  DATA_WIDTH  port A write data
read_data_a  out  DATA_WIDTH  port A read data
read_valid_a  out  1  one-cycle strobe, read_data_a valid
read_enable_b, write_enable_b, address_b, write_data_b, read_data_b, read_valid_b: same as port A, for port B
busy  out  1  zero-fill in progress; all requests ignored
collision  out  1  one-cycle strobe: both ports wrote the same address
addr_error  out  1  one-cycle strobe: a request used an address ≥ DEPTH

Behaviour:
- Reset (sampled high on a rising edge):
  - read_data_a/b = 0, read_valid_a/b = 0, collision = 0, addr_error = 0, pipeline stages flushed.
  - Sequencer enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY. Clear counter = 0.
  - Memory contents are untouched by reset itself.
- State machine:
  - CLEAR: busy = 1. One word per cycle, word[counter] = 0, counter += 1. After writing word DEPTH-1, next state is READY. Duration is exactly DEPTH cycles after reset deasserts.
  - READY: busy = 0. Normal operation.
  - Reset asserted mid-CLEAR restarts the fill at counter 0.
- While busy:
  - All enables are ignored.
  - No read_valid, collision or addr_error pulses.
- Write:
  - Memory updates on the rising edge where write_enable is sampled high, address < DEPTH and busy = 0.
- Read:
  - read_enable sampled high at edge N produces read_data and read_valid = 1 after edge N + READ_LATENCY - 1, i.e. visible during the following cycle(s).
  - Each request produces exactly one read_valid pulse.
  - read_data holds its last value when there is no new read.
  - Reads are fully pipelined: back-to-back requests give back-to-back valids.
- Read-during-write, same address (applies to same-port or cross-port):
  - RDW_NEW_DATA = 0: read returns the pre-write word.
  - RDW_NEW_DATA = 1: read returns the newly written word. If both ports wrote that address, it returns the winning port's data.
- Dual write, same address:
  - The winner per B_WINS is stored.
  - collision pulses high for one cycle, the cycle after the edge.
- Out of range (address ≥ DEPTH):
  - Write is dropped.
  - Read returns 0 with read_valid still asserted.
  - addr_error pulses for one cycle. A single pulse covers both ports if both are out of range.
- Ports A and B are fully independent otherwise; a simultaneous read on both ports to the same address returns the same word on both ports.

Test Plan:
1. DEPTH=16, CLEAR_ON_RESET=1: preload 0xFFFFFF everywhere, pulse reset for 1 cycle → busy=1 for exactly 16 cycles; afterwards reading every address returns 0x000000.
2. READ_LATENCY=1: A writes 0x123456 @3, next cycle B reads @3 → read_data_b=0x123456 with read_valid_b high one cycle later. READ_LATENCY=2: the same valid arrives one cycle later. Back-to-back B reads @3, @4 → two consecutive valid cycles.
3. A and B both write @5 (A=0xAAAAAA, B=0xBBBBBB), B_WINS=0 → collision pulses once; subsequent read @5 = 0xAAAAAA. With B_WINS=1 → 0xBBBBBB.
4. Word @7 = 0x000011; A writes 0x000022 @7 while B reads @7 in the same cycle → read_data_b=0x000011 with RDW_NEW_DATA=0, 0x000022 with RDW_NEW_DATA=1.
5. DEPTH=16: A writes 0x0F0F0F @20 → addr_error pulses; word @4 (aliased low bits) unchanged; read @20 returns 0 with valid.
6. Reset asserted at clear cycle 8 of 16, then released → busy stays high for a fresh 16 cycles. Reads issued while busy → no read_valid pulses.
